// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared types and helpers for the score digit driver.
//   state_e   : commit FSM states (IDLE, CONVERT, WAIT_FRAME)
//   bcd_t     : one packed BCD digit
//   max_score : largest value representable with n decimal digits (10^n - 1)
// -----------------------------------------------------------------------------
package score_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CONVERT    = 2'd1,
      WAIT_FRAME = 2'd2
   } state_e;

   typedef logic [3:0] bcd_t;

   // Elaboration-time helper; only ever used to build a constant.
   function automatic int unsigned max_score(input int unsigned n);
      int unsigned r;
      r = 32'd1;
      for (int unsigned k = 32'd0; k < n; k++) begin
         r = r * 32'd10;
      end
      return r - 32'd1;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble binary-to-BCD converter, one iteration per clock.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   start_i  : load score_i and clear the BCD scratch
//   score_i  : binary value to convert
//   done_o   : high during the final iteration cycle; bcd_o is valid after it
//   bcd_o    : BCD scratch, digit 0 (most significant) in the top nibble
// -----------------------------------------------------------------------------
module bin2bcd_seq
   import score_pkg::*;
#(
   parameter int unsigned SCORE_W    = 14,
   parameter int unsigned NUM_DIGITS = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [SCORE_W-1:0]      score_i,
   output logic                    done_o,
   output logic [4*NUM_DIGITS-1:0] bcd_o
);

   localparam int unsigned BCD_W = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W = $clog2(SCORE_W + 1);

   logic [SCORE_W-1:0]       bin_q;
   logic [BCD_W-1:0]         bcd_q;
   logic [CNT_W-1:0]         cnt_q;
   logic                     run_q;
   logic [BCD_W-1:0]         adj_s;
   logic [BCD_W+SCORE_W-1:0] sh_s;
   logic                     last_s;

   // Add-3 correction on every nibble >= 5, then the combined left shift.
   always_comb begin
      bcd_t nib;
      adj_s = bcd_q;
      for (int n = 0; n < int'(NUM_DIGITS); n++) begin
         nib = bcd_q[4*n +: 4];
         adj_s[4*n +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
      end
      sh_s = {adj_s, bin_q} << 1;
   end

   assign last_s = run_q && (cnt_q == CNT_W'(SCORE_W - 1));
   assign done_o = last_s;
   assign bcd_o  = bcd_q;

   // Conversion state: load on start, then exactly SCORE_W iterations.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start_i) begin
         bin_q <= score_i;
         bcd_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b1;
      end else if (run_q) begin
         bin_q <= sh_s[SCORE_W-1:0];
         bcd_q <= sh_s[BCD_W+SCORE_W-1:SCORE_W];
         cnt_q <= last_s ? '0 : (cnt_q + CNT_W'(1));
         run_q <= !last_s;
      end
   end

endmodule

// File: rtl/score_digit_driver.sv
// -----------------------------------------------------------------------------
// score_digit_driver
// Converts a binary score to BCD, commits the digits at frame start so the
// display never tears, and per pixel reports which digit/origin applies at
// the beam position together with a leading-zero blank enable.
// Ports:
//   pixel_clk_in, rst_in         : pixel clock, synchronous active-high reset
//   score_in, score_valid_in     : score request (accepted when !busy_out)
//   busy_out                     : conversion or commit pending
//   hcount_in, vcount_in         : beam position
//   hcount_out, vcount_out       : beam position delayed one cycle
//   number_out, x_out, y_out     : digit value and origin under the beam
//   digit_en_out                 : beam inside a non-blanked digit cell
// -----------------------------------------------------------------------------
module score_digit_driver
   import score_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned SCORE_W    = 14,
   parameter int unsigned DIGIT_W    = 24,
   parameter int unsigned DIGIT_H    = 24,
   parameter int unsigned GAP        = 2,
   parameter int unsigned X0         = 0,
   parameter int unsigned Y0         = 0
) (
   input  logic               pixel_clk_in,
   input  logic               rst_in,
   input  logic [SCORE_W-1:0] score_in,
   input  logic               score_valid_in,
   output logic               busy_out,
   input  logic [10:0]        hcount_in,
   input  logic [9:0]         vcount_in,
   output logic [10:0]        hcount_out,
   output logic [9:0]         vcount_out,
   output logic [3:0]         number_out,
   output logic [10:0]        x_out,
   output logic [9:0]         y_out,
   output logic               digit_en_out
);

   localparam int unsigned PITCH     = DIGIT_W + GAP;
   localparam int unsigned BCD_W     = 4 * NUM_DIGITS;
   localparam int unsigned MAX_SCORE = max_score(NUM_DIGITS);

   state_e                  state_q;
   logic                    busy_q;
   logic [BCD_W-1:0]        digits_q;
   logic [BCD_W-1:0]        bcd_s;
   logic                    conv_done_s;
   logic                    start_s;
   logic                    frame_start_s;
   logic [SCORE_W-1:0]      score_sat_s;

   logic [NUM_DIGITS-1:0]   match_s;
   logic [NUM_DIGITS-1:0]   blank_s;
   logic                    vin_s;
   bcd_t                    disp_s   [NUM_DIGITS];
   logic [10:0]             cell_x_s [NUM_DIGITS];

   logic [3:0]              number_d;
   logic [10:0]             x_d;
   logic                    en_d;
   logic [10:0]             hcount_q;
   logic [9:0]              vcount_q;
   logic [3:0]              number_q;
   logic [10:0]             x_q;
   logic [9:0]              y_q;
   logic                    en_q;

   assign start_s       = (state_q == IDLE) && score_valid_in;
   assign frame_start_s = (hcount_in == 11'd0) && (vcount_in == 10'd0);

   // Clamp to the largest displayable value (all 9s).
   always_comb begin
      if (32'(score_in) > MAX_SCORE) begin
         score_sat_s = SCORE_W'(MAX_SCORE);
      end else begin
         score_sat_s = score_in;
      end
   end

   bin2bcd_seq #(
      .SCORE_W    (SCORE_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_bin2bcd (
      .clk_i   (pixel_clk_in),
      .rst_i   (rst_in),
      .start_i (start_s),
      .score_i (score_sat_s),
      .done_o  (conv_done_s),
      .bcd_o   (bcd_s)
   );

   // Commit FSM: accept, wait out the conversion, publish at frame start.
   // A frame start during the last CONVERT cycle is missed on purpose.
   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         digits_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (score_valid_in) begin
                  state_q <= CONVERT;
                  busy_q  <= 1'b1;
               end
            end
            CONVERT: begin
               if (conv_done_s) begin
                  state_q <= WAIT_FRAME;
               end
            end
            WAIT_FRAME: begin
               if (frame_start_s) begin
                  digits_q <= bcd_s;
                  state_q  <= IDLE;
                  busy_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign vin_s = ({1'b0, vcount_in} >= 11'(Y0)) && ({1'b0, vcount_in} < 11'(Y0 + DIGIT_H));

   // Cell comparators use 12-bit constant bounds so the right edge cannot wrap.
   for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_cell
      localparam logic [11:0] CELL_LO = 12'(X0 + g * PITCH);
      localparam logic [11:0] CELL_HI = 12'(X0 + g * PITCH + DIGIT_W);
      assign match_s[g]  = ({1'b0, hcount_in} >= CELL_LO) &&
                           ({1'b0, hcount_in} <  CELL_HI) && vin_s;
      assign cell_x_s[g] = CELL_LO[10:0];
      assign disp_s[g]   = digits_q[4*(int'(NUM_DIGITS)-1-g) +: 4];
   end

   // Leading-zero blanking; the units digit is always shown.
   always_comb begin
      logic zero_prefix;
      zero_prefix = 1'b1;
      blank_s     = '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         zero_prefix = zero_prefix & (disp_s[i] == 4'd0);
         blank_s[i]  = zero_prefix & (i < int'(NUM_DIGITS) - 1);
      end
   end

   // One-hot select of the matching cell; all zeros when no cell matches.
   always_comb begin
      logic [10:0] x_or;
      number_d = 4'd0;
      x_or     = 11'd0;
      en_d     = 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         number_d = number_d | (match_s[i] ? disp_s[i] : 4'd0);
         x_or     = x_or | (match_s[i] ? cell_x_s[i] : 11'd0);
         en_d     = en_d | (match_s[i] & ~blank_s[i]);
      end
      x_d = (|match_s) ? x_or : 11'(X0);
   end

   // Pixel output registers, one cycle behind the beam inputs.
   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         hcount_q <= 11'd0;
         vcount_q <= 10'd0;
         number_q <= 4'd0;
         x_q      <= 11'd0;
         y_q      <= 10'(Y0);
         en_q     <= 1'b0;
      end else begin
         hcount_q <= hcount_in;
         vcount_q <= vcount_in;
         number_q <= number_d;
         x_q      <= x_d;
         y_q      <= 10'(Y0);
         en_q     <= en_d;
      end
   end

   assign busy_out     = busy_q;
   assign hcount_out   = hcount_q;
   assign vcount_out   = vcount_q;
   assign number_out   = number_q;
   assign x_out        = x_q;
   assign y_out        = y_q;
   assign digit_en_out = en_q;

endmodule

// File: doc/score_digit_driver.md
# score_digit_driver

Upstream feeder for the 1-bit transparent digit sprite renderer. Converts a binary score to BCD with a sequential double-dabble engine, commits new digits only at frame start (no tearing), and per pixel tells the sprite stage which digit value and x/y origin apply at the current beam position, plus a leading-zero blank enable. Sits between game logic (score source) and the digit sprite / pixel compositor in the pixel-clock domain.

## Interface
- NUM_DIGITS, 4, digits displayed; digit 0 is most significant and leftmost
- SCORE_W, 14, binary score width
- DIGIT_W, 24, sprite glyph width in pixels
- DIGIT_H, 24, sprite glyph height in pixels
- GAP, 2, blank pixels between glyphs; PITCH = DIGIT_W+GAP
- X0, 0, left edge of digit 0 (11-bit)
- Y0, 0, top edge of all digits (10-bit)
- pixel_clk_in  in  1  pixel clock, all logic on rising edge
- rst_in  in  1  synchronous, active-high reset
- score_in  in  SCORE_W  binary score, sampled when score_valid_in && !busy_out
- score_valid_in  in  1  request to display score_in
- busy_out  out  1  conversion or commit pending; new requests ignored
- hcount_in  in  11  beam column
- vcount_in  in  10  beam row
- hcount_out  out  11  hcount_in delayed 1 cycle
- vcount_out  out  10  vcount_in delayed 1 cycle
- number_out  out  4  BCD value of digit under beam (aligned to hcount_out)
- x_out  out  11  left edge of digit under beam
- y_out  out  10  always Y0
- digit_en_out  out  1  beam inside a non-blanked digit cell

## Operation
- FSM states IDLE, CONVERT, WAIT_FRAME.
- IDLE: on score_valid_in, latch min(score_in, 10^NUM_DIGITS-1) into shift register, clear BCD scratch, go CONVERT; busy_out high from next cycle.
- CONVERT: one double-dabble iteration per cycle (add 3 to each nibble ≥5, then shift left 1); exactly SCORE_W iterations, then WAIT_FRAME.
- WAIT_FRAME: on hcount_in==0 && vcount_in==0, copy scratch into displayed-digit register, go IDLE; busy_out low the following cycle. If frame start coincides with the last CONVERT cycle, commit waits for the next frame start.
- score_valid_in while busy_out high: dropped, no queueing.
- Saturation: scores above 10^NUM_DIGITS-1 display all 9s.
- Pixel path: digit i cell = hcount_in in [X0+i·PITCH, X0+i·PITCH+DIGIT_W) and vcount_in in [Y0, Y0+DIGIT_H). One-hot match across generated comparators; at most one true.
- In cell i: number_out = digit[i], x_out = X0+i·PITCH, digit_en_out = !blank[i].
- Outside all cells (incl. gaps): number_out=0, x_out=X0, digit_en_out=0.
- blank[i] = 1 iff digits 0..i are all zero and i < NUM_DIGITS-1; units digit never blanked.
- Arithmetic: cell bounds are elaborated constants at 12 bits to avoid wrap at right edge; no runtime multiply/divide.

## Timing
- Pixel outputs registered, latency 1 cycle; number_out, x_out, digit_en_out always coherent with hcount_out/vcount_out.
- Score latency: accept cycle + SCORE_W CONVERT cycles + wait to frame start; displayed digits change on the cycle after commit.
- Reset: state IDLE, busy_out=0, displayed digits 0, scratch 0, all pixel outputs 0, y_out=Y0 after first clock. Reset mid-conversion aborts; pending score lost, display reverts to 0.

## Structure
- Package score_pkg: state enum (IDLE, CONVERT, WAIT_FRAME), bcd_t (4-bit digit) typedef, function for 10^NUM_DIGITS-1 constant.
- Sub-module bin2bcd_seq: start/score in, done/bcd out, owns shift register, iteration counter and add-3 logic; top module holds FSM commit, blanking and pixel mapping.

## Test plan
- Reset then score 1234 valid one cycle -> busy_out high 14+ cycles; after next (0,0) beam, cell 0..3 give number_out 1,2,3,4, all digit_en_out=1.
- Score 7 -> cells 0-2 digit_en_out=0, cell 3 number_out=7 enable 1; score 0 -> only cell 3 enabled, number_out=0.
- Score 16383 -> all cells number_out=9 (saturation).
- Beam sweep row Y0: hcount 24,25 (gap) -> digit_en_out=0; hcount 26 -> x_out=26, cell 1; hcount_out always equals prior-cycle hcount_in.
- Second score_valid_in during CONVERT -> ignored, first value displayed; score change before frame start -> old digits persist until (0,0).
- rst_in asserted mid-CONVERT -> busy_out 0 next cycle, display 0, subsequent request accepted normally.
